uart_code_loader: RTL
=====================

// Module: uart_code_loader
// PURPOSE
//   Writer side of the BXU code store. Receives a framed program over the UART receive handshake,
//   assembles 16-bit code words (low byte first) and writes them into the code RAM that the BXU reads.
//   Holds the BXU via 'hold' until a frame is loaded and its checksum passes.
//   Sits between u_uart (rx side) and the code RAM write port.
// PARAMETERS
//   CODE_BITWIDTH   16         code word width; must be 16 (two bytes per word)
//   ADDR_BITWIDTH   16         code RAM address width
//   DEPTH           256        code RAM depth in words; larger frame lengths are rejected
//   SYNC_BYTE       8'hA5      frame start marker
//   TIMEOUT_CYCLES  5_000_000  max clk cycles between bytes inside a frame
// PORTS
//   clk        in   1              clock
//   rst        in   1              synchronous reset, active-high
//   rx_data    in   8              received byte, valid while rx_ready=1
//   rx_ready   in   1              byte available from UART receiver
//   rx_done    out  1              one-cycle acknowledge of the byte
//   code_addr  out  ADDR_BITWIDTH  code RAM write address
//   code_data  out  CODE_BITWIDTH  code RAM write data
//   code_wr    out  1              code RAM write strobe, one cycle per word
//   hold       out  1              BXU hold; 1 = BXU held in reset
//   busy       out  1              frame in progress (any state except IDLE)
//   load_ok    out  1              sticky: last frame loaded and checksum matched
//   load_err   out  1              sticky: last frame failed (checksum, length or timeout)
// BEHAVIOUR
//   Reset: state=IDLE; rx_done=0, code_wr=0, code_addr=0, code_data=0, busy=0, load_ok=0, load_err=0, hold=1.
//   Byte accept: in a cycle with rx_ready=1 and armed=1:
//     - capture rx_data;
//     - pulse rx_done for exactly the next cycle;
//     - clear armed.
//     armed sets again only after rx_ready is sampled 0, so one byte is never consumed twice.
//   Frame: SYNC, LEN_LO, LEN_HI (LEN = number of words), LEN x {W_LO, W_HI}, CSUM.
//     CSUM = XOR of every byte after SYNC (LEN bytes and payload bytes).
//   States:
//     IDLE:    non-SYNC bytes are acked and dropped. SYNC -> LEN_LO; hold=1, load_ok=0, load_err=0,
//              csum=0, code_addr=0, busy=1.
//     LEN_LO -> LEN_HI.
//     LEN_HI:  if LEN > DEPTH -> ERR. If LEN == 0 -> CSUM. Otherwise -> W_LO.
//     W_LO:    store low byte -> W_HI.
//     W_HI:    code_data = {byte, low}; code_wr=1 in the cycle after the accept. code_addr holds the
//              word index during the strobe and increments the cycle after it. After word LEN-1 -> CSUM,
//              otherwise -> W_LO.
//     CSUM:    byte == csum -> IDLE with load_ok=1, hold=0. Mismatch -> ERR.
//     ERR:     load_err=1, hold stays 1, next cycle -> IDLE.
//   Timeout: counter clears on each byte accept, counts in every state except IDLE.
//     Reaching TIMEOUT_CYCLES -> ERR. Words already written stay in RAM but hold stays 1.
//   SYNC_BYTE inside a frame is treated as data; no resync until the frame ends.
//   csum is an 8-bit XOR. code_addr is ADDR_BITWIDTH wide; LEN <= DEPTH so code_addr never wraps.
//   Reset mid-frame: return to the reset values immediately. A partial RAM image is not cleared.
//   rx_ready rising in the same cycle a strobe or state change occurs: the byte is accepted normally.
//   There is no back-pressure beyond the single-cycle ack.
// TESTING
//   T1 frame A5 02 00 34 12 78 56 0A -> writes [0]=1234, [1]=5678; load_ok=1, hold=0, load_err=0.
//   T2 same frame with CSUM 0B -> both words written; load_err=1, load_ok=0, hold=1; state returns to IDLE.
//   T3 bytes 00 FF then A5 00 00 00 -> leading bytes acked and dropped; LEN=0 gives no code_wr, load_ok=1.
//   T4 A5 01 01 (LEN=257 > DEPTH=256) -> load_err=1, no code_wr; the next valid frame loads normally.
//   T5 A5 01 00 34 then silence for TIMEOUT_CYCLES -> load_err=1, busy=0, hold=1.
//   T6 rx_ready held high 10 cycles for one byte -> exactly one rx_done pulse and one byte consumed;
//      rst=1 mid-frame -> all outputs return to reset values on the next clk edge.

Source files
------------

// File: rtl/uart_code_loader.sv
// UART code loader: receives a framed program and writes 16-bit words into the BXU code RAM.
// Frame: A5, LEN_LO, LEN_HI, LEN x {W_LO, W_HI}, CSUM (XOR of every byte after the sync byte).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rx_data, rx_ready    byte from UART receiver; rx_done acknowledges it for one cycle
//   code_addr/data/wr    code RAM write port; one strobe per assembled word
//   hold                 holds the BXU until a frame loads with a good checksum
//   busy                 frame in progress
//   load_ok, load_err    sticky outcome of the last frame
module uart_code_loader #(
  parameter int          CODE_BITWIDTH  = 16,
  parameter int          ADDR_BITWIDTH  = 16,
  parameter int          DEPTH          = 256,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  output logic                     rx_done,
  output logic [ADDR_BITWIDTH-1:0] code_addr,
  output logic [CODE_BITWIDTH-1:0] code_data,
  output logic                     code_wr,
  output logic                     hold,
  output logic                     busy,
  output logic                     load_ok,
  output logic                     load_err
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, W_LO, W_HI, CSUM, ERR
  } state_t;

  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        armed;
  logic [7:0]  csum;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  lo_byte;
  logic [31:0] timer;
  logic        acc;
  logic [15:0] len_in;
  logic        in_frame;

  assign acc      = rx_ready & armed;
  assign len_in   = {rx_data, len_lo};
  assign in_frame = (state != IDLE) && (state != ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      csum      <= 8'd0;
      len_lo    <= 8'd0;
      len       <= 16'd0;
      lo_byte   <= 8'd0;
      timer     <= 32'd0;
      rx_done   <= 1'b0;
      code_addr <= '0;
      code_data <= '0;
      code_wr   <= 1'b0;
      hold      <= 1'b1;
      busy      <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      code_wr <= 1'b0;
      // Re-arm only after rx_ready drops so a held byte is consumed once.
      if (!rx_ready) armed <= 1'b1;
      // Address advances the cycle after each write strobe.
      if (code_wr) code_addr <= code_addr + ADDR_BITWIDTH'(1);
      if (state != IDLE) timer <= timer + 32'd1;
      if (acc) begin
        armed   <= 1'b0;
        rx_done <= 1'b1;
        timer   <= 32'd0;
        if (state != IDLE) csum <= csum ^ rx_data;
      end
      unique case (state)
        IDLE: begin
          if (acc && rx_data == SYNC_BYTE) begin
            state     <= LEN_LO;
            hold      <= 1'b1;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            csum      <= 8'd0;
            code_addr <= '0;
            busy      <= 1'b1;
          end
        end
        LEN_LO: begin
          if (acc) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (acc) begin
            len <= len_in;
            if ({1'b0, len_in} > DEPTH_W) state <= ERR;
            else if (len_in == 16'd0)     state <= CSUM;
            else                          state <= W_LO;
          end
        end
        W_LO: begin
          if (acc) begin
            lo_byte <= rx_data;
            state   <= W_HI;
          end
        end
        W_HI: begin
          if (acc) begin
            code_data <= CODE_BITWIDTH'({rx_data, lo_byte});
            code_wr   <= 1'b1;
            if (code_addr == ADDR_BITWIDTH'(len - 16'd1))
              state <= CSUM;
            else
              state <= W_LO;
          end
        end
        CSUM: begin
          if (acc) begin
            if (rx_data == csum) begin
              state   <= IDLE;
              load_ok <= 1'b1;
              hold    <= 1'b0;
              busy    <= 1'b0;
            end else begin
              state <= ERR;
            end
          end
        end
        ERR: begin
          load_err <= 1'b1;
          busy     <= 1'b0;
          timer    <= 32'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A stalled sender aborts the frame; words already written stay.
      if (!acc && in_frame && timer >= TMO_LAST) state <= ERR;
    end
  end

endmodule
